// File: rtl/sseg_scan_decoder_pkg.sv
// Shared definitions for the seven-segment scan decoder: segment patterns,
// FSM states, per-digit record and anode-to-index helper.
package sseg_scan_decoder_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIG_IDX_W  = 2;

    // Active-low {g,f,e,d,c,b,a} patterns as driven by the display.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_9_ALT = 7'h18;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURED
    } state_e;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
    } sample_t;

    typedef struct packed {
        logic [3:0] nib;
        logic       dp;
        logic       blank;
        logic       minus;
    } digit_t;

    // Only meaningful when exactly one anode is low.
    function automatic logic [DIG_IDX_W-1:0] anode_to_idx(input logic [3:0] an_n);
        case (an_n)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/sseg_scan_decoder_if.sv
// Display bus seen by the scan decoder plus the decoded frame it reports.
interface sseg_scan_decoder_if;

    logic [7:0]  seg;
    logic [3:0]  an;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  minus;
    logic        frame_vld;
    logic        chg;
    logic        err_pat;
    logic        err_multi;

    modport master (
        output seg, an,
        input  digits, dp, blank, minus, frame_vld, chg, err_pat, err_multi
    );

    modport slave (
        input  seg, an,
        output digits, dp, blank, minus, frame_vld, chg, err_pat, err_multi
    );

endinterface

// File: rtl/sseg_pattern_decode.sv
// Combinational map from an active-low 7-segment pattern to its hex digit,
// flagging blank, minus and undecodable patterns.
module sseg_pattern_decode
    import sseg_scan_decoder_pkg::*;
(
    input  logic [6:0] pat,
    output logic       valid,
    output logic       blank,
    output logic       minus,
    output logic [3:0] nibble
);

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        valid  = 1'b1;
        blank  = 1'b0;
        minus  = 1'b0;
        nibble = 4'h0;
        case (pat)
            SEG_0:            nibble = 4'h0;
            SEG_1:            nibble = 4'h1;
            SEG_2:            nibble = 4'h2;
            SEG_3:            nibble = 4'h3;
            SEG_4:            nibble = 4'h4;
            SEG_5:            nibble = 4'h5;
            SEG_6:            nibble = 4'h6;
            SEG_7:            nibble = 4'h7;
            SEG_8:            nibble = 4'h8;
            SEG_9, SEG_9_ALT: nibble = 4'h9;
            SEG_A:            nibble = 4'hA;
            SEG_B:            nibble = 4'hB;
            SEG_C:            nibble = 4'hC;
            SEG_D:            nibble = 4'hD;
            SEG_E:            nibble = 4'hE;
            SEG_F:            nibble = 4'hF;
            SEG_BLANK:        blank  = 1'b1;
            SEG_MINUS:        minus  = 1'b1;
            default:          valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Samples a multiplexed seven-segment bus, captures each settled digit and
// commits complete four-digit frames with change and error reporting.
module sseg_scan_decoder
    import sseg_scan_decoder_pkg::*;
#(
    parameter int SETTLE = 4
) (
    input logic                CLK,
    input logic                RST,
    sseg_scan_decoder_if.slave bus
);

    localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);

    sample_t                       in_d, in_q, last_q;
    state_e                        state_d, state_q;
    logic [7:0]                    cnt_d, cnt_q;
    logic [NUM_DIGITS-1:0]         mask_d, mask_q;
    digit_t [NUM_DIGITS-1:0]       shadow_d, shadow_q;
    digit_t [NUM_DIGITS-1:0]       frame_d, frame_q;
    logic                          frame_vld_d, frame_vld_q;
    logic                          chg_d, chg_q;
    logic                          err_pat_d, err_pat_q;
    logic                          err_multi_d, err_multi_q;

    logic [3:0]                    an_low;
    logic                          multi;
    logic [DIG_IDX_W-1:0]          idx;
    logic                          dec_valid, dec_blank, dec_minus;
    logic [3:0]                    dec_nib;

    assign in_d   = '{an: bus.an, seg: bus.seg};
    assign an_low = ~in_q.an;
    assign multi  = |(an_low & (an_low - 4'd1));
    assign idx    = anode_to_idx(in_q.an);

    sseg_pattern_decode u_decode (
        .pat    (in_q.seg[6:0]),
        .valid  (dec_valid),
        .blank  (dec_blank),
        .minus  (dec_minus),
        .nibble (dec_nib)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mask_d      = mask_q;
        shadow_d    = shadow_q;
        frame_d     = frame_q;
        frame_vld_d = 1'b0;
        chg_d       = 1'b0;
        err_pat_d   = 1'b0;
        err_multi_d = 1'b0;

        // A mask completed by last cycle's capture is committed now.
        if (mask_q == '1) begin
            frame_d     = shadow_q;
            frame_vld_d = 1'b1;
            chg_d       = (shadow_q != frame_q);
            mask_d      = '0;
        end

        if (multi) begin
            err_multi_d = 1'b1;
            mask_d      = '0;
            state_d     = ST_IDLE;
            cnt_d       = '0;
        end else if (in_q.an == 4'hF) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_SETTLE;
                    cnt_d   = 8'd1;
                end
                ST_SETTLE: begin
                    cnt_d = (in_q == last_q) ? cnt_q + 8'd1 : 8'd1;
                end
                ST_CAPTURED: begin
                    if (in_q.an != last_q.an) begin
                        state_d = ST_SETTLE;
                        cnt_d   = 8'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // Leaving for CAPTURED guarantees one capture per dwell.
            if (state_d == ST_SETTLE && cnt_d == SETTLE_CNT) begin
                state_d = ST_CAPTURED;
                if (dec_valid) begin
                    shadow_d[idx] = '{nib: dec_nib, dp: ~in_q.seg[7],
                                      blank: dec_blank, minus: dec_minus};
                    mask_d[idx]   = 1'b1;
                end else begin
                    err_pat_d = 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: shadow and frame storage is reset too, so a stale partial
            // frame can never leak into a commit after reset.
            in_q        <= '{an: 4'hF, seg: 8'hFF};
            last_q      <= '{an: 4'hF, seg: 8'hFF};
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mask_q      <= '0;
            shadow_q    <= '0;
            frame_q     <= '0;
            frame_vld_q <= 1'b0;
            chg_q       <= 1'b0;
            err_pat_q   <= 1'b0;
            err_multi_q <= 1'b0;
        end else begin
            in_q        <= in_d;
            last_q      <= in_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            shadow_q    <= shadow_d;
            frame_q     <= frame_d;
            frame_vld_q <= frame_vld_d;
            chg_q       <= chg_d;
            err_pat_q   <= err_pat_d;
            err_multi_q <= err_multi_d;
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_out
        assign bus.digits[4*i +: 4] = frame_q[i].nib;
        assign bus.dp[i]            = frame_q[i].dp;
        assign bus.blank[i]         = frame_q[i].blank;
        assign bus.minus[i]         = frame_q[i].minus;
    end

    assign bus.frame_vld = frame_vld_q;
    assign bus.chg       = chg_q;
    assign bus.err_pat   = err_pat_q;
    assign bus.err_multi = err_multi_q;

endmodule
